// File: rtl/ram_cmd_sequencer.sv
// ============================================================================
// Module   : ram_cmd_sequencer
// Purpose  : Debounced push-button command stage for the dual-port RAM demo;
//            each press runs one command chosen by sw[9:8]. Optional macro
//            RAM_CMD_AUTOINC_EN advances write_addr after every write strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_cmd_sequencer #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_n,
   input  logic [9:0]            sw,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  we,
   output logic [3:0]            sel_onehot,
   output logic                  busy
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   logic                  key_meta_q, key_sync_q;
   logic [9:0]            sw_meta_q, sw_sync_q;
   logic                  key_deb_q, key_deb_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  press_q, press_d;
   state_t                state_q, state_d;
   logic [1:0]            cmd_q, cmd_d;
   logic [7:0]            opnd_q, opnd_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;

   // Debounce: a level change must persist DEBOUNCE_CYCLES clocks to be accepted.
   always_comb begin
      key_deb_d = key_deb_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      if (key_sync_q != key_deb_q) begin
         if (cnt_q == CNT_LAST) begin
            key_deb_d = key_sync_q;
            press_d   = ~key_sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      opnd_d  = opnd_q;
      data_d  = data_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      we_d    = 1'b0;
`ifdef RAM_CMD_AUTOINC_EN
      if (we_q) begin
         waddr_d = waddr_q + ADDR_WIDTH'(1);
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (press_q) begin
               state_d = S_EXEC;
               cmd_d   = sw_sync_q[9:8];
               opnd_d  = sw_sync_q[7:0];
            end
         end
         S_EXEC: begin
            state_d = S_HOLD;
            case (cmd_q)
               2'b00:   data_d  = opnd_q[DATA_WIDTH-1:0];
               2'b01:   raddr_d = opnd_q[ADDR_WIDTH-1:0];
               2'b10:   waddr_d = opnd_q[ADDR_WIDTH-1:0];
               default: we_d    = 1'b1;
            endcase
         end
         S_HOLD: begin
            if (key_deb_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Key synchronizer resets to the released level so reset never fakes a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_meta_q <= 1'b1;
         key_sync_q <= 1'b1;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_deb_q  <= 1'b1;
         cnt_q      <= '0;
         press_q    <= 1'b0;
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         opnd_q     <= '0;
         data_q     <= '0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         key_meta_q <= key_n;
         key_sync_q <= key_meta_q;
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         key_deb_q  <= key_deb_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         opnd_q     <= opnd_d;
         data_q     <= data_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
      end
   end

   assign data_in    = data_q;
   assign read_addr  = raddr_q;
   assign write_addr = waddr_q;
   assign we         = we_q;
   assign busy       = busy_q;
   assign sel_onehot = 4'b0001 << sw_sync_q[9:8];

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_sequencer.sv
// Testbench for ram_cmd_sequencer: directed presses checked against a
// cycle-level reference model plus hand-computed expectations.
`default_nettype none

module tb_ram_cmd_sequencer;
   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int DEB = 4;
`ifdef RAM_CMD_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          key_n = 1'b1;
   logic [9:0]    sw    = '0;
   logic [DW-1:0] data_in;
   logic [AW-1:0] read_addr;
   logic [AW-1:0] write_addr;
   logic          we;
   logic [3:0]    sel_onehot;
   logic          busy;

   ram_cmd_sequencer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .sw(sw),
      .data_in(data_in), .read_addr(read_addr), .write_addr(write_addr),
      .we(we), .sel_onehot(sel_onehot), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw inputs become visible two clocks late; a command
   // starts the clock after the debounced press, takes effect one clock later,
   // and the sequencer stays busy until the debounced release is seen.
   logic          k_hist [2];
   logic [9:0]    s_hist [2];
   logic          m_lvl, m_press, m_we;
   int            m_run, m_phase;
   logic [1:0]    m_cmd;
   logic [7:0]    m_opnd;
   logic [DW-1:0] m_data;
   logic [AW-1:0] m_ra, m_wa;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k_hist[0] = 1'b1; k_hist[1] = 1'b1;
         s_hist[0] = '0;   s_hist[1] = '0;
         m_lvl = 1'b1; m_press = 1'b0; m_we = 1'b0; m_run = 0; m_phase = 0;
         m_cmd = '0; m_opnd = '0; m_data = '0; m_ra = '0; m_wa = '0;
      end else begin
         logic       ks, prev_we, prev_lvl, prev_press;
         logic [9:0] ss;
         ks = k_hist[1]; ss = s_hist[1];
         prev_we = m_we; prev_lvl = m_lvl; prev_press = m_press;
         k_hist[1] = k_hist[0]; k_hist[0] = key_n;
         s_hist[1] = s_hist[0]; s_hist[0] = sw;
         m_press = 1'b0;
         if (ks != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
               m_lvl = ks; m_run = 0; m_press = ~ks;
            end
         end else begin
            m_run = 0;
         end
         m_we = 1'b0;
         if (prev_we && AUTOINC) m_wa = m_wa + 1'b1;
         if (m_phase == 0) begin
            if (prev_press) begin
               m_phase = 1; m_cmd = ss[9:8]; m_opnd = ss[7:0];
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
            if (m_cmd == 2'b00)      m_data = m_opnd[DW-1:0];
            else if (m_cmd == 2'b01) m_ra   = m_opnd[AW-1:0];
            else if (m_cmd == 2'b10) m_wa   = m_opnd[AW-1:0];
            else                     m_we   = 1'b1;
         end else if (prev_lvl) begin
            m_phase = 0;
         end
      end
   end

   int            n_we = 0, n_cmd = 0;
   logic          busy_prev = 1'b0;
   logic [DW-1:0] we_data = '0;
   logic [AW-1:0] we_wa = '0;

   always @(negedge clk) begin
      if (!rst) begin
         chk("data_in", 32'(data_in), 32'(m_data));
         chk("read_addr", 32'(read_addr), 32'(m_ra));
         chk("write_addr", 32'(write_addr), 32'(m_wa));
         chk("we", 32'(we), 32'(m_we));
         chk("busy", 32'(busy), 32'(m_phase != 0));
         chk("sel_onehot", 32'(sel_onehot), 32'(4'b0001 << s_hist[1][9:8]));
         if (we) begin
            n_we++; we_data = data_in; we_wa = write_addr;
         end
         if (busy && !busy_prev) n_cmd++;
         busy_prev = busy;
      end else begin
         busy_prev = 1'b0;
      end
   end

   task automatic press(input logic [9:0] v);
      sw = v; key_n = 1'b0;
      repeat (DEB + 8) @(negedge clk);
      key_n = 1'b1;
      repeat (DEB + 8) @(negedge clk);
   endtask

   initial begin
      int n0, w0;
      logic seen;
      sw = 10'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_data_in", 32'(data_in), 32'h0);
      chk("rst_addrs", 32'({read_addr, write_addr}), 32'h0);
      chk("rst_we_busy", 32'({we, busy}), 32'h0);
      chk("rst_sel", 32'(sel_onehot), 32'h1);
      sw = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_sel", 32'(sel_onehot), 32'h1);

      // Load data, load write address, then write.
      press(10'b00_1010_0101);
      chk("load_data", 32'(data_in), 32'hA5);
      press(10'b10_0000_0011);
      chk("load_waddr", 32'(write_addr), 32'h3);
      w0 = n_we;
      press(10'b11_0000_0000);
      chk("we_count", 32'(n_we - w0), 32'd1);
      chk("we_data", 32'(we_data), 32'hA5);
      chk("we_waddr", 32'(we_wa), 32'h3);

      // Bouncing key settles low: one command only.
      n0 = n_cmd;
      sw = 10'b01_0101_0101;
      for (int i = 0; i < 10; i++) begin
         key_n = ~key_n;
         repeat (2) @(negedge clk);
      end
      key_n = 1'b0;
      repeat (20) @(negedge clk);
      chk("bounce_one_cmd", 32'(n_cmd - n0), 32'd1);
      chk("bounce_raddr", 32'(read_addr), 32'h5);
      repeat (100) @(negedge clk);
      chk("held_no_second", 32'(n_cmd - n0), 32'd1);
      key_n = 1'b1;
      repeat (DEB + 8) @(negedge clk);

      // Switch change while busy is ignored until the next press.
      n0 = n_cmd;
      sw = 10'b01_0000_0111; key_n = 1'b0;
      repeat (12) @(negedge clk);
      chk("busy_in_hold", 32'(busy), 32'h1);
      sw = 10'b01_0000_1001;
      repeat (10) @(negedge clk);
      chk("sw_change_ignored", 32'(read_addr), 32'h7);
      chk("sw_change_no_cmd", 32'(n_cmd - n0), 32'd1);
      key_n = 1'b1;
      repeat (DEB + 8) @(negedge clk);
      chk("idle_after_release", 32'(busy), 32'h0);
      press(10'b01_0000_1001);
      chk("new_sw_applied", 32'(read_addr), 32'h9);

      // Write at the top address.
      press(10'b10_0000_1111);
      w0 = n_we;
      press(10'b11_0000_0000);
      chk("top_we_count", 32'(n_we - w0), 32'd1);
      chk("top_we_waddr", 32'(we_wa), 32'hF);
`ifdef RAM_CMD_AUTOINC_EN
      chk("waddr_wrap", 32'(write_addr), 32'h0);
`else
      chk("waddr_hold", 32'(write_addr), 32'hF);
`endif

      // Reset during EXEC of a write cancels the strobe.
      w0 = n_we;
      sw = 10'b11_0000_0000; key_n = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("exec_reached", 32'(seen), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_exec_outs", 32'({we, busy, write_addr, data_in}), 32'h0);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_exec_no_we", 32'(n_we - w0), 32'd0);
      chk("rst_exec_idle", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_cmd_sequencer.md
# ram_cmd_sequencer

Upstream command stage for the board-level dual-port RAM demo. It synchronizes and debounces a push-button and the slide switches. On each debounced press it executes exactly one command selected by `sw[9:8]`: load the data register, load the read address, load the write address, or issue a single-cycle RAM write strobe. It replaces free-running level enables with clean, registered, one-shot control, so a held switch setting cannot repeatedly write memory.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of `data_in`; must be ≤ 8.
- `ADDR_WIDTH`, 4, width of both address outputs; must be ≤ 8.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new button level; must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_n`  in  1  raw push-button, active-low, asynchronous to `clk`.
- `sw`  in  10  raw slide switches: `[9:8]` command select, `[7:0]` operand.
- `data_in`  out  DATA_WIDTH  registered write data for the RAM.
- `read_addr`  out  ADDR_WIDTH  registered RAM read address.
- `write_addr`  out  ADDR_WIDTH  registered RAM write address.
- `we`  out  1  RAM write strobe, one cycle per write command.
- `sel_onehot`  out  4  one-hot decode of synchronized `sw[9:8]`, used for the display decimal points.
- `busy`  out  1  high while in EXEC or HOLD.

## Operation
- **Synchronizers:** two-flop synchronizer on `key_n` and on all of `sw`. All logic uses only the synchronized copies.
- **Debouncer:**
  - The counter resets whenever the synchronized key equals the debounced level.
  - Otherwise it counts up. When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A bounce before terminal count restarts the count.
  - `press` is a one-cycle pulse on the debounced released→pressed transition.
- **FSM states:** IDLE, EXEC, HOLD.
  - IDLE → EXEC on `press`. `cmd` is latched from synchronized `sw[9:8]` and `opnd` from `sw[7:0]` in the same cycle.
  - EXEC → HOLD unconditionally, after one cycle.
  - HOLD → IDLE when the debounced level is released.
  - `press` is ignored outside IDLE.
- **Commands** (executed in EXEC and registered at the end of that cycle):
  - `00`: `data_in <= opnd[DATA_WIDTH-1:0]`.
  - `01`: `read_addr <= opnd[ADDR_WIDTH-1:0]`.
  - `10`: `write_addr <= opnd[ADDR_WIDTH-1:0]`.
  - `11`: `we <= 1` for exactly one cycle; `data_in` and `write_addr` are held.
- Registers not targeted by the command hold their value.
- `sel_onehot` updates combinationally from synchronized `sw[9:8]` and is independent of the FSM.

## Timing
- **Reset values:**
  - `data_in`, `read_addr`, `write_addr` = 0.
  - `we`, `busy` = 0.
  - `sel_onehot` = 4'b0001 (synchronizers reset to 0).
  - FSM in IDLE; debounced level = released; counter = 0.
- **Latency:**
  - Raw `key_n` fall → `press`: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
  - `press` → EXEC: next cycle.
  - EXEC → register update or `we` high: next cycle.
- **`we` shape:** high exactly one cycle per write press. `data_in` and `write_addr` are stable throughout that cycle.
- **Held key:** produces one command only. The next command requires a debounced release followed by a new press.
- **Switch change while busy:** no effect on the latched `cmd`/`opnd`.
- **Key held through reset deassert:** treated as a new press after `DEBOUNCE_CYCLES`, so one command executes.
- **Reset asserted mid-EXEC or HOLD:**
  - All outputs return to reset values immediately.
  - A pending `we` is cancelled.
- **Address wrap:** see Configuration.

## Configuration
- Macro: `RAM_CMD_AUTOINC_EN`.
- **Defined:** on the clock edge ending the `we` cycle, `write_addr <= write_addr + 1`, modulo 2^ADDR_WIDTH (for example 15 → 0 when ADDR_WIDTH = 4). The RAM therefore samples the pre-increment address, and consecutive write presses fill sequential locations.
- **Not defined:** `write_addr` changes only via command `10`.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `rst` with random `sw` → all outputs at reset values, `sel_onehot` = 0001 after deassert and 2 cycles.
- **Load and write sequence:**
  - Press with `sw` = 10'b00_1010_0101 → `data_in` = 0xA5.
  - Press with `sw` = 10'b10_0000_0011 → `write_addr` = 3.
  - Press with `sw[9:8]` = 11 → `we` high exactly 1 cycle with `data_in` = 0xA5 and `write_addr` = 3.
- **Bounce:** toggle `key_n` every 2 cycles for 20 cycles, then hold low → exactly one command executes. Hold low for 100 cycles → no second command.
- **Switch change while busy:** change `sw` during HOLD → `cmd`/`opnd` unchanged and no extra update; after release and a new press, the new `sw` is applied.
- **Autoincrement** (with `RAM_CMD_AUTOINC_EN`): `write_addr` = 15, write press → `we` pulse at address 15, then `write_addr` = 0. Without the macro, `write_addr` stays 15.
- **Reset in EXEC:** assert `rst` in EXEC with `cmd` = 11 → `we` never asserts, FSM returns to IDLE.
